// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer for a PWM generator's duty_cycle input.
// Accepts a target level and walks the duty level toward it one step per STEP_PERIODS PWM periods.
module pwm_ramp_controller #(
    parameter int PERIOD_CYCLES = 16,
    parameter int STEP_PERIODS  = 4,
    parameter int INIT_LEVEL    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] target_level,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       abort,
    output logic [3:0] duty_cycle,
    output logic [4:0] level,
    output logic       busy,
    output logic       done,
    output logic       period_start
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_PERIODS - 1);
    localparam logic [4:0]    INIT_LVL    = 5'(INIT_LEVEL);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] step_cnt, step_nxt;
    logic [4:0]    target_q, target_nxt;
    logic [4:0]    level_nxt, level_step, target_clamped;
    logic          done_nxt;
    logic          wrap;

    assign wrap         = (period_cnt == PERIOD_LAST);
    assign period_start = (period_cnt == '0);
    // Level 16 aliases to 4'h0, which the PWM generator treats as 100%.
    assign duty_cycle   = level[3:0];

    always_comb begin
        target_clamped = target_level;
        if (target_level == 5'd0)
            target_clamped = 5'd1;
        else if (target_level > 5'd16)
            target_clamped = 5'd16;
    end

    assign level_step = (target_q > level) ? level + 5'd1 : level - 5'd1;

    always_comb begin
        state_nxt    = state;
        level_nxt    = level;
        target_nxt   = target_q;
        step_nxt     = step_cnt;
        done_nxt     = 1'b0;
        target_ready = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                target_ready = 1'b1;
                if (target_valid) begin
                    target_nxt = target_clamped;
                    step_nxt   = '0;
                    if (target_clamped == level)
                        done_nxt = 1'b1;
                    else
                        state_nxt = RAMP;
                end
            end
            default: begin
                busy = 1'b1;
                // abort takes priority over a step landing in the same cycle
                if (abort) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    if (step_cnt == STEP_LAST) begin
                        step_nxt  = '0;
                        level_nxt = level_step;
                        if (level_step == target_q) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        step_nxt = step_cnt + SW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            step_cnt   <= '0;
            target_q   <= INIT_LVL;
            level      <= INIT_LVL;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            period_cnt <= wrap ? '0 : period_cnt + PW'(1);
            step_cnt   <= step_nxt;
            target_q   <= target_nxt;
            level      <= level_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller at default parameters (one step per 64 clk).
module tb_pwm_ramp_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] target_level = 5'd0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic       abort = 1'b0;
    logic [3:0] duty_cycle;
    logic [4:0] level;
    logic       busy;
    logic       done;
    logic       period_start;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    pwm_ramp_controller dut (
        .clk          (clk),
        .rst          (rst),
        .target_level (target_level),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .abort        (abort),
        .duty_cycle   (duty_cycle),
        .level        (level),
        .busy         (busy),
        .done         (done),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    // advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) done_cnt++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic align();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic accept(input logic [4:0] tgt);
        target_level = tgt;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    // full ramp from a period-aligned accept; checks every step position
    task automatic ramp(input logic [4:0] tgt, input logic [4:0] from, input logic [4:0] to);
        int n, a, d0;
        logic [4:0] exp_lvl;
        align();
        a = cyc;
        d0 = done_cnt;
        accept(tgt);
        chk("busy_on", busy, 1);
        chk("ready_low", target_ready, 0);
        n = (to > from) ? to - from : from - to;
        exp_lvl = from;
        for (int k = 1; k <= n; k++) begin
            while (cyc < a + 64 * k - 1) tick();
            chk("pre_step_lvl", level, exp_lvl);
            tick();
            exp_lvl = (to > from) ? exp_lvl + 5'd1 : exp_lvl - 5'd1;
            chk("step_lvl", level, exp_lvl);
            chk("step_pstart", period_start, 1);
            chk("step_duty", duty_cycle, exp_lvl[3:0]);
        end
        chk("done_pulse", done, 1);
        chk("busy_off", busy, 0);
        chk("ready_back", target_ready, 1);
        tick();
        chk("done_low", done, 0);
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int a, d0;

        // 1: reset state and period_start cadence
        do_reset(2);
        chk("rst_level", level, 1);
        chk("rst_duty", duty_cycle, 4'h1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", target_ready, 1);
        chk("pstart_c0", period_start, 1);
        tick();
        chk("pstart_c1", period_start, 0);
        while (cyc < 15) tick();
        chk("pstart_c15", period_start, 0);
        tick();
        chk("pstart_c16", period_start, 1);
        while (cyc < 32) tick();
        chk("pstart_c32", period_start, 1);

        // 2: ramp up 1 -> 8
        ramp(5'd8, 5'd1, 5'd8);

        // 3: clamp high to 16, then clamp low to 1
        ramp(5'd20, 5'd8, 5'd16);
        chk("full_duty", duty_cycle, 4'h0);
        ramp(5'd0, 5'd16, 5'd1);
        chk("min_duty", duty_cycle, 4'h1);

        // 4: same target, with abort ignored in IDLE
        ramp(5'd5, 5'd1, 5'd5);
        d0 = done_cnt;
        abort = 1'b1;
        accept(5'd5);
        abort = 1'b0;
        chk("same_done", done, 1);
        chk("same_busy", busy, 0);
        chk("same_level", level, 5);
        tick();
        chk("same_done_low", done, 0);
        chk("same_busy2", busy, 0);
        chk("same_done_once", done_cnt - d0, 1);

        // 5: abort after 3rd step, then abort coincident with a step
        do_reset(2);
        a = cyc;
        d0 = done_cnt;
        accept(5'd12);
        while (cyc < a + 192) tick();
        chk("abort_pre_lvl", level, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", target_ready, 1);
        chk("abort_lvl", level, 4);
        repeat (130) tick();
        chk("abort_hold", level, 4);
        chk("abort_no_done", done_cnt - d0, 0);

        align();
        a = cyc;
        d0 = done_cnt;
        accept(5'd10);
        while (cyc < a + 63) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("coinc_lvl", level, 4);
        chk("coinc_busy", busy, 0);
        repeat (70) tick();
        chk("coinc_hold", level, 4);
        chk("coinc_no_done", done_cnt - d0, 0);

        // 6: valid ignored while busy, then reset mid-ramp
        do_reset(2);
        ramp(5'd8, 5'd1, 5'd8);
        align();
        a = cyc;
        accept(5'd2);
        target_level = 5'd16;
        target_valid = 1'b1;
        while (cyc < a + 64) tick();
        chk("busy_ignore_rdy", target_ready, 0);
        chk("busy_ignore_lvl", level, 7);
        chk("busy_ignore_busy", busy, 1);
        target_valid = 1'b0;
        d0 = done_cnt;
        do_reset(1);
        chk("midrst_lvl", level, 1);
        chk("midrst_duty", duty_cycle, 4'h1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", target_ready, 1);
        chk("midrst_pstart", period_start, 1);
        repeat (200) tick();
        chk("midrst_lvl_hold", level, 1);
        chk("midrst_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
